// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if
//   Local-side bus of the SPI target core: transmit holding register write port,
//   receive word valid/ack handshake and status pulses.
//   slave modport  : seen by spi_slave_core
//   master modport : seen by the local consumer (register file / FIFO / bench)
// Signals
//   tx_din      next word to send
//   tx_load     write strobe for tx_din (accepted while tx_ready=1)
//   tx_ready    holding register empty
//   rx_dout     last received word
//   rx_valid    rx_dout holds an unacknowledged word
//   rx_ack      consumer acknowledges rx_dout
//   rx_overrun  1-clk pulse, word completed while rx_valid=1
//   tx_underrun 1-clk pulse, shifter load found holding register empty
//   busy        frame in progress
interface spi_slave_core_if #(
  parameter int DWIDTH = 8
) ();
  logic [DWIDTH-1:0] tx_din;
  logic              tx_load;
  logic              tx_ready;
  logic [DWIDTH-1:0] rx_dout;
  logic              rx_valid;
  logic              rx_ack;
  logic              rx_overrun;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  tx_din, tx_load, rx_ack,
    output tx_ready, rx_dout, rx_valid, rx_overrun, tx_underrun, busy
  );

  modport master (
    output tx_din, tx_load, rx_ack,
    input  tx_ready, rx_dout, rx_valid, rx_overrun, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI target (CPOL=0) end of the SPI link. ss_n/sclk/mosi are oversampled on clk
//   through 2-FF synchronisers; DWIDTH-bit words are shifted MSB-first. mosi is
//   sampled on sclk rising edges, miso advances on sclk falling edges, and the MSB
//   of every word is presented before its first rising edge.
// Ports
//   clk      system clock (posedge)
//   rst      asynchronous reset, active-low
//   ss_n     slave select, active-low, asynchronous
//   sclk     SPI clock from master, asynchronous
//   mosi     master-out data, asynchronous
//   miso     slave-out data
//   miso_oe  miso pad output enable
//   bus      local side (tx holding register, rx valid/ack, status)
module spi_slave_core #(
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  spi_slave_core_if.slave       bus
);

  localparam int CW = $clog2(DWIDTH) + 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]        state;
  logic [1:0]        ss_s, sclk_s, mosi_s;
  logic              ss_d, sclk_d;
  logic              ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [DWIDTH-1:0] hold, tx_sh, rx_sh, rx_dout;
  logic [CW-1:0]     cnt;
  logic              tx_ready, rx_valid, rx_overrun, tx_underrun;
  logic              word_done, reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_s   <= '1;
      ss_d   <= 1'b1;
      sclk_s <= '0;
      sclk_d <= 1'b0;
      mosi_s <= '0;
    end else begin
      ss_s   <= {ss_s[0], ss_n};
      ss_d   <= ss_s[1];
      sclk_s <= {sclk_s[0], sclk};
      sclk_d <= sclk_s[1];
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  always_comb begin
    ss_fall   = ss_d & ~ss_s[1];
    ss_rise   = ~ss_d & ss_s[1];
    sclk_rise = sclk_s[1] & ~sclk_d;
    sclk_fall = ~sclk_s[1] & sclk_d;
    // Completion is evaluated one clk after the last rising edge, independent of
    // state, so a word finishing just as ss_n rises is still delivered.
    word_done = (cnt == CW'(DWIDTH));
    // Shifter (re)load: frame start, or a falling edge on a word boundary.
    reload    = ((state == IDLE) && ss_fall) ||
                ((state == ACTIVE) && !ss_rise && sclk_fall && (cnt == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      hold        <= '0;
      tx_ready    <= 1'b1;
      tx_sh       <= '0;
      rx_sh       <= '0;
      rx_dout     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      cnt         <= '0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;

      // A same-clk load and reload can only coincide with an empty holding
      // register: the shifter gets zeros and the new word is kept for later.
      if (bus.tx_load && tx_ready) begin
        hold     <= bus.tx_din;
        tx_ready <= 1'b0;
      end else if (reload) begin
        tx_ready <= 1'b1;
      end

      if (reload) begin
        tx_sh       <= tx_ready ? '0 : hold;
        tx_underrun <= tx_ready;
      end

      if (word_done) begin
        rx_dout    <= rx_sh;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~bus.rx_ack;
      end else if (bus.rx_ack) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state <= ACTIVE;
            cnt   <= '0;
          end
        end
        default: begin
          if (ss_rise) begin
            state <= IDLE;
            cnt   <= '0;
            tx_sh <= '0;
          end else begin
            if (word_done) begin
              cnt <= '0;
            end else if (sclk_rise) begin
              rx_sh <= {rx_sh[DWIDTH-2:0], mosi_s[1]};
              cnt   <= cnt + CW'(1);
            end
            if (sclk_fall && (cnt != '0)) begin
              tx_sh <= {tx_sh[DWIDTH-2:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

  assign miso            = tx_sh[DWIDTH-1];
  assign miso_oe         = (state == ACTIVE);
  assign bus.busy        = (state == ACTIVE);
  assign bus.tx_ready    = tx_ready;
  assign bus.rx_dout     = rx_dout;
  assign bus.rx_valid    = rx_valid;
  assign bus.rx_overrun  = rx_overrun;
  assign bus.tx_underrun = tx_underrun;

endmodule
